// File: rtl/avalon_arb_pkg.sv
// Shared types and helpers for the Avalon-ST round-robin arbiter.
// Provides the FSM state enum, channel-width helper and round-robin search function.
package avalon_arb_pkg;

   typedef enum logic {
      ST_IDLE,
      ST_LOCK
   } state_t;

   // Upper bound on sources that the search function can scan.
   localparam int MAX_SRC = 64;

   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // First set bit of req, scanning ptr, ptr+1, ... modulo n; 0 when nothing is set.
   function automatic int rr_search(input logic [MAX_SRC-1:0] req, input int ptr, input int n);
      int   idx;
      logic found;
      rr_search = 0;
      found     = 1'b0;
      for (int k = 0; k < n; k++) begin
         idx = (ptr + k) % n;
         if (!found && req[idx[5:0]]) begin
            rr_search = idx;
            found     = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/avalon_st_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: index of the first request at or after ptr, wrapping.
// 'any' is high when at least one request is present.
module rr_pick
   import avalon_arb_pkg::*;
#(
   parameter int N    = 4,
   parameter int CH_W = 2
) (
   input  logic [N-1:0]    req,
   input  logic [CH_W-1:0] ptr,
   output logic [CH_W-1:0] idx,
   output logic            any
);

   logic [MAX_SRC-1:0] req_ext;

   assign req_ext = MAX_SRC'(req);
   assign idx     = CH_W'(rr_search(req_ext, int'(ptr), N));
   assign any     = |req;

endmodule

// File: rtl/avalon_st_rr_arbiter.sv
// Packet-locked round-robin arbiter sharing one Avalon-ST sink among N_SRC sources.
// Define ARB_OUT_REG_EN to register the output through a 2-entry skid buffer (+1 cycle latency).
module avalon_st_rr_arbiter
   import avalon_arb_pkg::*;
#(
   parameter int N_SRC     = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BEATS = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_SRC-1:0]          in_valid,
   output logic [N_SRC-1:0]          in_ready,
   input  logic [N_SRC*DATA_W-1:0]   in_data,
   input  logic [N_SRC-1:0]          in_eop,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         out_data,
   output logic                      out_eop,
   output logic [$clog2(N_SRC)-1:0]  out_channel,
   output logic                      out_trunc
);

   localparam int CH_W  = ch_w(N_SRC);
   localparam int CNT_W = (MAX_BEATS == 0) ? 1 : $clog2(MAX_BEATS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((MAX_BEATS == 0) ? 0 : MAX_BEATS - 1);
   localparam logic [CH_W-1:0]  LAST_SRC = CH_W'(N_SRC - 1);

   state_t            state;
   logic [CH_W-1:0]   ptr;
   logic [CH_W-1:0]   grant;
   logic [CH_W-1:0]   pick_idx;
   logic              pick_any;
   logic [CNT_W-1:0]  beat_cnt;
   logic              lock;
   logic              g_valid;
   logic              g_eop;
   logic [DATA_W-1:0] g_data;
   logic              hit_max;
   logic              beat_eop;
   logic              beat_trunc;
   logic              sink_ready;
   logic              take;

   rr_pick #(
      .N    (N_SRC),
      .CH_W (CH_W)
   ) u_pick (
      .req (in_valid),
      .ptr (ptr),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign lock       = (state == ST_LOCK);
   assign g_valid    = in_valid[grant];
   assign g_eop      = in_eop[grant];
   assign g_data     = in_data[grant*DATA_W +: DATA_W];
   assign hit_max    = (MAX_BEATS != 0) && (beat_cnt == LAST_CNT);
   assign beat_eop   = g_eop | hit_max;
   assign beat_trunc = hit_max & ~g_eop;
   assign take       = lock & g_valid & sink_ready;

   always_comb begin
      // NOTE: default assignment first so no path leaves in_ready unassigned (no latch).
      in_ready = '0;
      if (lock) in_ready[grant] = sink_ready;
   end

   // Grant only moves in IDLE, so a stalled beat keeps its source until accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         ptr      <= '0;
         grant    <= '0;
         beat_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  grant <= pick_idx;
                  state <= ST_LOCK;
               end
            end
            ST_LOCK: begin
               if (take) begin
                  if (beat_eop) begin
                     state    <= ST_IDLE;
                     ptr      <= (grant == LAST_SRC) ? '0 : grant + 1'b1;
                     beat_cnt <= '0;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef ARB_OUT_REG_EN
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              eop;
      logic              trunc;
      logic [CH_W-1:0]   ch;
   } beat_t;

   beat_t      buf_q [2];
   beat_t      head;
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] count;
   logic       push;
   logic       pop;

   assign sink_ready = (count != 2'd2);
   assign push       = take;
   assign pop        = (count != 2'd0) & out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: only two entries, so they are reset to present zeros on the outputs after reset.
         for (int i = 0; i < 2; i++) buf_q[i] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            buf_q[wr_ptr] <= '{data: g_data, eop: beat_eop, trunc: beat_trunc, ch: grant};
            wr_ptr        <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign head        = buf_q[rd_ptr];
   assign out_valid   = (count != 2'd0);
   assign out_data    = head.data;
   assign out_eop     = head.eop;
   assign out_trunc   = head.trunc;
   assign out_channel = head.ch;
`else
   assign sink_ready  = out_ready;
   assign out_valid   = lock & g_valid;
   assign out_data    = lock ? g_data : '0;
   assign out_eop     = lock & beat_eop;
   assign out_trunc   = lock & beat_trunc;
   assign out_channel = grant;
`endif

endmodule

// File: tb/tb_avalon_st_rr_arbiter.sv
// Directed testbench for avalon_st_rr_arbiter (N_SRC=4, DATA_W=8, MAX_BEATS=4).
// Works with and without ARB_OUT_REG_EN; LAT accounts for the skid-buffer latency.
`timescale 1ns/1ps
module tb_avalon_st_rr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MB = 4;
`ifdef ARB_OUT_REG_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  in_valid;
   logic [N-1:0]  in_ready;
   logic [N*DW-1:0] in_data;
   logic [N-1:0]  in_eop;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_eop;
   logic [1:0]    out_channel;
   logic          out_trunc;

   always #5 clk = ~clk;

   avalon_st_rr_arbiter #(
      .N_SRC     (N),
      .DATA_W    (DW),
      .MAX_BEATS (MB)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_eop      (in_eop),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_eop     (out_eop),
      .out_channel (out_channel),
      .out_trunc   (out_trunc)
   );

   typedef struct {
      logic [7:0] data;
      logic       eop;
   } src_beat_t;

   typedef struct {
      logic [7:0] data;
      logic       eop;
      logic       trunc;
      logic [1:0] ch;
      int         cyc;
   } out_beat_t;

   src_beat_t src_q [N][$];
   int        src_start [N];
   out_beat_t log_q [$];
   int        cyc;
   logic      drv_ready;
   int        checks;
   int        failures;

   task automatic push_beat(input int ch, input logic [7:0] d, input logic e);
      src_beat_t b;
      b.data = d;
      b.eop  = e;
      src_q[ch].push_back(b);
   endtask

   // One clock cycle: drive sources at negedge, sample just before the next posedge.
   task automatic tick();
      out_beat_t ob;
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
         if (src_q[i].size() > 0 && cyc >= src_start[i]) begin
            in_valid[i]          = 1'b1;
            in_data[i*DW +: DW]  = src_q[i][0].data;
            in_eop[i]            = src_q[i][0].eop;
         end else begin
            in_valid[i]          = 1'b0;
            in_data[i*DW +: DW]  = 8'h00;
            in_eop[i]            = 1'b0;
         end
      end
      out_ready = drv_ready;
      #4;
      if (out_valid && out_ready) begin
         ob.data  = out_data;
         ob.eop   = out_eop;
         ob.trunc = out_trunc;
         ob.ch    = out_channel;
         ob.cyc   = cyc;
         log_q.push_back(ob);
      end
      for (int i = 0; i < N; i++)
         if (in_valid[i] && in_ready[i]) void'(src_q[i].pop_front());
   endtask

   task automatic reset_dut();
      reset     = 1'b1;
      drv_ready = 1'b1;
      out_ready = 1'b1;
      in_valid  = '0;
      in_data   = '0;
      in_eop    = '0;
      for (int i = 0; i < N; i++) begin
         src_q[i].delete();
         src_start[i] = 0;
      end
      log_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      cyc   = -1;
   endtask

   task automatic run_until(input int n, input int budget);
      int k;
      k = 0;
      while (log_q.size() < n && k < budget) begin
         tick();
         k++;
      end
      checks++;
      if (log_q.size() < n) begin
         failures++;
         $display("FAIL timeout: beats=%0d required=%0d", log_q.size(), n);
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      in_valid  = '1;
      in_eop    = '1;
      in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
      out_ready = 1'b1;
      @(negedge clk);
      #4;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++;
      if (in_ready !== 4'b0000) begin failures++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
      checks++;
      if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data: got %h want 00", out_data); end
      checks++;
      if (out_eop !== 1'b0) begin failures++; $display("FAIL reset_out_eop: got %b want 0", out_eop); end
      checks++;
      if (out_trunc !== 1'b0) begin failures++; $display("FAIL reset_out_trunc: got %b want 0", out_trunc); end
      checks++;
      if (out_channel !== 2'd0) begin failures++; $display("FAIL reset_out_channel: got %0d want 0", out_channel); end
   endtask

   task automatic test_single();
      logic [7:0] exp_d [3];
      exp_d = '{8'h04, 8'h05, 8'h06};
      reset_dut();
      push_beat(2, 8'h04, 1'b0);
      push_beat(2, 8'h05, 1'b0);
      push_beat(2, 8'h06, 1'b1);
      run_until(3, 40);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (log_q[k].data !== exp_d[k] || log_q[k].ch !== 2'd2 ||
             log_q[k].eop !== (k == 2) || log_q[k].trunc !== 1'b0) begin
            failures++;
            $display("FAIL single_beat%0d: got data=%h ch=%0d eop=%b trunc=%b want data=%h ch=2 eop=%b trunc=0",
                     k, log_q[k].data, log_q[k].ch, log_q[k].eop, log_q[k].trunc, exp_d[k], (k == 2));
         end
      end
      checks++;
      if (log_q[0].cyc !== 1 + LAT) begin
         failures++;
         $display("FAIL single_first_cycle: got %0d want %0d", log_q[0].cyc, 1 + LAT);
      end
      checks++;
      if (log_q[2].cyc - log_q[0].cyc !== 2) begin
         failures++;
         $display("FAIL single_contiguous: got span %0d want 2", log_q[2].cyc - log_q[0].cyc);
      end
      // After ch2 the pointer is 3, so ch3 wins over ch0.
      push_beat(0, 8'h0A, 1'b1);
      push_beat(3, 8'h3A, 1'b1);
      src_start[0] = cyc + 1;
      src_start[3] = cyc + 1;
      run_until(5, 40);
      checks++;
      if (log_q[3].ch !== 2'd3 || log_q[3].data !== 8'h3A) begin
         failures++;
         $display("FAIL single_next_ptr: got ch=%0d data=%h want ch=3 data=3a", log_q[3].ch, log_q[3].data);
      end
      checks++;
      if (log_q[4].ch !== 2'd0 || log_q[4].data !== 8'h0A) begin
         failures++;
         $display("FAIL single_wrap: got ch=%0d data=%h want ch=0 data=0a", log_q[4].ch, log_q[4].data);
      end
   endtask

   task automatic test_round_robin();
      logic [7:0] exp_d [8];
      logic [1:0] exp_c [8];
      exp_d = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01, 8'h11, 8'h21, 8'h31};
      exp_c = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
      reset_dut();
      for (int ch = 0; ch < N; ch++) begin
         push_beat(ch, 8'(ch * 16), 1'b1);
         push_beat(ch, 8'(ch * 16 + 1), 1'b1);
      end
      run_until(8, 60);
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (log_q[k].ch !== exp_c[k] || log_q[k].data !== exp_d[k] || log_q[k].eop !== 1'b1) begin
            failures++;
            $display("FAIL rr_beat%0d: got ch=%0d data=%h eop=%b want ch=%0d data=%h eop=1",
                     k, log_q[k].ch, log_q[k].data, log_q[k].eop, exp_c[k], exp_d[k]);
         end
      end
      for (int k = 1; k < 8; k++) begin
         checks++;
         if (log_q[k].cyc - log_q[k-1].cyc !== 2) begin
            failures++;
            $display("FAIL rr_bubble%0d: got gap %0d want 2", k, log_q[k].cyc - log_q[k-1].cyc);
         end
      end
      checks++;
      if (log_q[0].cyc !== 1 + LAT) begin
         failures++;
         $display("FAIL rr_first_cycle: got %0d want %0d", log_q[0].cyc, 1 + LAT);
      end
   endtask

   task automatic test_stall();
      int s;
      logic [7:0] exp_d [3];
      exp_d = '{8'h11, 8'h12, 8'h13};
      s = 2 + LAT;
      reset_dut();
      push_beat(1, 8'h11, 1'b0);
      push_beat(1, 8'h12, 1'b0);
      push_beat(1, 8'h13, 1'b1);
      for (int c = 0; c < s + 3; c++) begin
         drv_ready = !(c >= s);
         tick();
         if (c >= s) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h12 || out_channel !== 2'd1) begin
               failures++;
               $display("FAIL stall_hold_c%0d: got valid=%b data=%h ch=%0d want valid=1 data=12 ch=1",
                        c, out_valid, out_data, out_channel);
            end
            checks++;
            if ((in_ready & 4'b1101) !== 4'b0000) begin
               failures++;
               $display("FAIL stall_other_ready_c%0d: got %b want x0xx zeros", c, in_ready);
            end
            if (LAT == 0 || c > s) begin
               checks++;
               if (in_ready[1] !== 1'b0) begin
                  failures++;
                  $display("FAIL stall_ready1_c%0d: got %b want 0", c, in_ready[1]);
               end
            end
         end
      end
      drv_ready = 1'b1;
      run_until(3, 30);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (log_q[k].data !== exp_d[k] || log_q[k].eop !== (k == 2)) begin
            failures++;
            $display("FAIL stall_beat%0d: got data=%h eop=%b want data=%h eop=%b",
                     k, log_q[k].data, log_q[k].eop, exp_d[k], (k == 2));
         end
      end
   endtask

   task automatic test_trunc();
      logic [7:0] exp_d [7];
      logic [1:0] exp_c [7];
      logic       exp_e [7];
      logic       exp_t [7];
      exp_d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hA4, 8'hA5};
      exp_c = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
      exp_e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      exp_t = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      reset_dut();
      for (int k = 0; k < 6; k++) push_beat(0, 8'(8'hA0 + k), 1'b0);
      push_beat(1, 8'hB0, 1'b1);
      run_until(7, 60);
      for (int k = 0; k < 7; k++) begin
         checks++;
         if (log_q[k].data !== exp_d[k] || log_q[k].ch !== exp_c[k] ||
             log_q[k].eop !== exp_e[k] || log_q[k].trunc !== exp_t[k]) begin
            failures++;
            $display("FAIL trunc_beat%0d: got data=%h ch=%0d eop=%b trunc=%b want data=%h ch=%0d eop=%b trunc=%b",
                     k, log_q[k].data, log_q[k].ch, log_q[k].eop, log_q[k].trunc,
                     exp_d[k], exp_c[k], exp_e[k], exp_t[k]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic found;
      reset_dut();
      push_beat(2, 8'h20, 1'b1);
      run_until(1, 20);
      push_beat(3, 8'h31, 1'b0);
      push_beat(3, 8'h32, 1'b0);
      push_beat(3, 8'h33, 1'b1);
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         tick();
         if (in_valid[3] && in_ready[3] && in_data[3*DW +: DW] == 8'h32) found = 1'b1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL rstmid_beat2: got no accepted beat 32 want accepted");
      end
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_pre_valid: got %b want 1", out_valid);
      end
      reset = 1'b1;
      #0.5;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_out_valid: got %b want 0", out_valid);
      end
      checks++;
      if (in_ready !== 4'b0000) begin
         failures++;
         $display("FAIL rstmid_in_ready: got %b want 0000", in_ready);
      end
      reset_dut();
      push_beat(1, 8'h1A, 1'b1);
      push_beat(3, 8'h3A, 1'b1);
      run_until(1, 20);
      checks++;
      if (log_q[0].ch !== 2'd1 || log_q[0].data !== 8'h1A) begin
         failures++;
         $display("FAIL rstmid_ptr_cleared: got ch=%0d data=%h want ch=1 data=1a", log_q[0].ch, log_q[0].data);
      end
   endtask

   task automatic test_simultaneous();
      reset_dut();
      push_beat(0, 8'h01, 1'b0);
      push_beat(0, 8'h02, 1'b1);
      push_beat(1, 8'h1A, 1'b1);
      src_start[1] = 2;
      repeat (3) tick();
      checks++;
      if (in_ready !== 4'b0001) begin
         failures++;
         $display("FAIL simul_eop_ready: got %b want 0001", in_ready);
      end
      tick();
      checks++;
      if (in_ready !== 4'b0000) begin
         failures++;
         $display("FAIL simul_bubble_ready: got %b want 0000", in_ready);
      end
      run_until(3, 20);
      checks++;
      if (log_q[1].ch !== 2'd0 || log_q[1].data !== 8'h02 || log_q[1].eop !== 1'b1) begin
         failures++;
         $display("FAIL simul_eop_beat: got ch=%0d data=%h eop=%b want ch=0 data=02 eop=1",
                  log_q[1].ch, log_q[1].data, log_q[1].eop);
      end
      checks++;
      if (log_q[2].ch !== 2'd1 || log_q[2].data !== 8'h1A) begin
         failures++;
         $display("FAIL simul_next_grant: got ch=%0d data=%h want ch=1 data=1a", log_q[2].ch, log_q[2].data);
      end
      checks++;
      if (log_q[2].cyc - log_q[1].cyc !== 2) begin
         failures++;
         $display("FAIL simul_bubble_gap: got %0d want 2", log_q[2].cyc - log_q[1].cyc);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      checks    = 0;
      failures  = 0;
      cyc       = -1;
      drv_ready = 1'b1;
      reset     = 1'b1;
      in_valid  = '0;
      in_data   = '0;
      in_eop    = '0;
      out_ready = 1'b1;
      test_reset();
      test_single();
      test_round_robin();
      test_stall();
      test_trunc();
      test_reset_mid();
      test_simultaneous();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
